// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared types, size codes and alignment helper for the load/store RAM adapter
package lsu_pkg;

    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LD  = 3'b011,
        LBU = 3'b100,
        LHU = 3'b101,
        LWU = 3'b110
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC0,
        ST_ACC1,
        ST_RESP
    } lsu_state_e;

    // Access size codes, identical to funct3[1:0] for both loads and stores.
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = addr_lo[0];
            SZ_W:    bad = |addr_lo[1:0];
            default: bad = |addr_lo;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - combinational store lane merge and load lane extract/extend
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     ram_word,
    input  logic [31:0]     wdata,
    input  logic [1:0]      size,
    input  logic [1:0]      offset,
    input  logic            is_unsigned,
    output logic [31:0]     new_word,
    output logic [XLEN-1:0] load_data
);

    logic [31:0] shifted;
    logic [4:0]  byte_pos;
    logic [4:0]  half_pos;

    assign byte_pos = {offset, 3'b000};
    assign half_pos = {offset[1], 4'b0000};
    assign shifted  = ram_word >> byte_pos;

    // W and D both write the low store word unmodified; only B/H merge with the old word.
    always_comb begin
        new_word = ram_word;
        case (size)
            SZ_B:    new_word[byte_pos +: 8]  = wdata[7:0];
            SZ_H:    new_word[half_pos +: 16] = wdata[15:0];
            default: new_word = wdata;
        endcase
    end

    always_comb begin
        load_data = '0;
        case (size)
            SZ_B: begin
                if (is_unsigned) load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
                else             load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                if (is_unsigned) load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
                else             load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            end
            default: begin
                if (is_unsigned) load_data = {{(XLEN-32){1'b0}}, shifted};
                else             load_data = {{(XLEN-32){shifted[31]}}, shifted};
            end
        endcase
    end

endmodule

// File: rtl/lsu_ram_adapter.sv
// rtl/lsu_ram_adapter.sv - RV64 load/store to 32-bit word RAM adapter; LSU_BOUNDS_CHECK_EN enables range errors
module lsu_ram_adapter
    import lsu_pkg::*;
#(
    parameter int N    = 20,
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_err,
    output logic            ram_we,
    output logic [N-1:0]    ram_addr,
    output logic [31:0]     ram_din,
    input  logic [31:0]     ram_dout
);

    lsu_state_e      state;
    logic            we_q;
    logic [2:0]      f3_q;
    logic [N+1:0]    addr_q;
    logic [XLEN-1:0] wdata_q;
    logic [31:0]     lo_q;

    logic [1:0]      size_q;
    logic [31:0]     merged;
    logic [XLEN-1:0] load_ext;
    logic            out_of_range;
    logic            req_bad;

    assign size_q    = f3_q[1:0];
    assign req_ready = (state == ST_IDLE);

`ifdef LSU_BOUNDS_CHECK_EN
    assign out_of_range = |req_addr[XLEN-1:N+2];
`else
    logic [XLEN-N-3:0] unused_addr_hi;
    assign unused_addr_hi = req_addr[XLEN-1:N+2];
    assign out_of_range   = 1'b0;
`endif

    assign req_bad = is_misaligned(req_funct3[1:0], req_addr[2:0]) || out_of_range;

    lsu_lane_align #(
        .XLEN (XLEN)
    ) u_lane (
        .ram_word    (ram_dout),
        .wdata       (wdata_q[31:0]),
        .size        (size_q),
        .offset      (addr_q[1:0]),
        .is_unsigned (f3_q[2]),
        .new_word    (merged),
        .load_data   (load_ext)
    );

    // RAM port is decoded from the state register so a reset drops ram_we at once.
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        case (state)
            ST_ACC0: begin
                ram_addr = addr_q[N+1:2];
                if (we_q) begin
                    ram_we  = 1'b1;
                    ram_din = merged;
                end
            end
            ST_ACC1: begin
                ram_addr = addr_q[N+1:2] + N'(1);
                if (we_q) begin
                    ram_we  = 1'b1;
                    ram_din = wdata_q[63:32];
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            we_q       <= 1'b0;
            f3_q       <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            lo_q       <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        f3_q    <= req_funct3;
                        addr_q  <= req_addr[N+1:0];
                        wdata_q <= req_wdata;
                        if (req_bad) begin
                            state      <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else begin
                            state <= ST_ACC0;
                        end
                    end
                end
                ST_ACC0: begin
                    if (!we_q) lo_q <= ram_dout;
                    if (size_q == SZ_D) begin
                        state <= ST_ACC1;
                    end else begin
                        state      <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= 1'b0;
                        resp_rdata <= we_q ? '0 : load_ext;
                    end
                end
                ST_ACC1: begin
                    state      <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= we_q ? '0 : {ram_dout, lo_q};
                end
                default: begin
                    state      <= ST_IDLE;
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ram_adapter.sv
// tb/tb_lsu_ram_adapter.sv - scoreboard bench for lsu_ram_adapter against a byte-level memory model
module tb_lsu_ram_adapter;

`ifdef LSU_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        ram_we;
    logic [19:0] ram_addr;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    logic [31:0] ram [0:(1<<20)-1];
    logic [31:0] model [int];

    typedef struct {
        logic [63:0] rdata;
        logic        err;
        int          lat;
        int          wes;
    } exp_t;
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign ram_dout = ram[ram_addr];
    always @(posedge clk) if (ram_we) ram[ram_addr] <= ram_din;

    lsu_ram_adapter #(.N(20), .XLEN(64)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mbyte(input logic [63:0] a);
        logic [21:0] w;
        logic [31:0] word;
        w = a[21:0];
        word = model.exists(int'(w[21:2])) ? model[int'(w[21:2])] : 32'h0;
        return word[8*w[1:0] +: 8];
    endfunction

    task automatic set_byte(input logic [63:0] a, input logic [7:0] b);
        logic [21:0] w;
        logic [31:0] word;
        w = a[21:0];
        word = model.exists(int'(w[21:2])) ? model[int'(w[21:2])] : 32'h0;
        word[8*w[1:0] +: 8] = b;
        model[int'(w[21:2])] = word;
    endtask

    function automatic logic [63:0] model_load(input logic [63:0] a, input int nbytes, input logic uns);
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < nbytes; i++) v[8*i +: 8] = mbyte(a + 64'(i));
        if (!uns && nbytes < 8 && v[8*nbytes-1])
            for (int i = 8*nbytes; i < 64; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic model_store(input logic [63:0] a, input int nbytes, input logic [63:0] d);
        for (int i = 0; i < nbytes; i++) set_byte(a + 64'(i), d[8*i +: 8]);
    endtask

    task automatic preload(input int widx, input logic [31:0] val);
        ram[widx] = val;
        model[widx] = val;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wdata, output logic [63:0] rdata);
        exp_t e, g;
        int nbytes, cyc, wes, wait_n;
        nbytes = 1 << f3[1:0];
        e.err  = ((addr % 64'(nbytes)) != 0) || (BOUNDS && addr[63:22] != 0);
        e.lat  = e.err ? 1 : (nbytes == 8 ? 3 : 2);
        e.wes  = (e.err || !we) ? 0 : (nbytes == 8 ? 2 : 1);
        e.rdata = (e.err || we) ? 64'h0 : model_load(addr, nbytes, f3[2]);
        sb.push_back(e);
        if (!e.err && we) model_store(addr, nbytes, wdata);
        rdata = '0;

        @(negedge clk);
        wait_n = 0;
        while (!req_ready && wait_n < 10) begin
            @(negedge clk);
            wait_n++;
        end
        if (!req_ready) check_eq("ready_timeout", 64'(req_ready), 64'h1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;

        cyc = 0;
        wes = 0;
        while (cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (ram_we) wes++;
            if (resp_valid) break;
        end
        g = sb.pop_front();
        if (!resp_valid) begin
            check_eq("resp_timeout", 64'(resp_valid), 64'h1);
        end else begin
            rdata = resp_rdata;
            check_eq("rdata", resp_rdata, g.rdata);
            check_eq("err", 64'(resp_err), 64'(g.err));
            check_eq("latency", 64'(cyc), 64'(g.lat));
            check_eq("we_pulses", 64'(wes), 64'(g.wes));
        end
    endtask

    logic [63:0] rd;

    initial begin
        for (int i = 0; i < (1 << 20); i++) ram[i] = 32'h0;

        #12;
        check_eq("rst_ready", 64'(req_ready), 64'h1);
        check_eq("rst_resp_valid", 64'(resp_valid), 64'h0);
        check_eq("rst_ram_we", 64'(ram_we), 64'h0);
        check_eq("rst_rdata", resp_rdata, 64'h0);
        check_eq("rst_err", 64'(resp_err), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        preload(32'h1000, 32'h8899AABB);
        do_req(1'b0, 3'b000, 64'h4003, 64'h0, rd);
        check_eq("lb_const", rd, 64'hFFFF_FFFF_FFFF_FF88);
        do_req(1'b0, 3'b100, 64'h4003, 64'h0, rd);
        check_eq("lbu_const", rd, 64'h0000_0000_0000_0088);

        do_req(1'b1, 3'b001, 64'h4002, 64'h1234, rd);
        check_eq("sh_mem", 64'(ram[32'h1000]), 64'h1234AABB);

        do_req(1'b1, 3'b011, 64'h8000, 64'h0123_4567_89AB_CDEF, rd);
        check_eq("sd_mem_lo", 64'(ram[32'h2000]), 64'h89ABCDEF);
        check_eq("sd_mem_hi", 64'(ram[32'h2001]), 64'h01234567);
        do_req(1'b0, 3'b011, 64'h8000, 64'h0, rd);
        check_eq("ld_const", rd, 64'h0123_4567_89AB_CDEF);

        do_req(1'b0, 3'b010, 64'h4002, 64'h0, rd);
        do_req(1'b1, 3'b011, 64'h8004, 64'hFFFF_FFFF_FFFF_FFFF, rd);
        check_eq("err_mem_a", 64'(ram[32'h2001]), 64'h01234567);
        check_eq("err_mem_b", 64'(ram[32'h2002]), 64'h0);

        preload(0, 32'hCAFEF00D);
        do_req(1'b0, 3'b010, 64'h0040_0000, 64'h0, rd);
`ifdef LSU_BOUNDS_CHECK_EN
        check_eq("bounds_err_data", rd, 64'h0);
`else
        check_eq("bounds_wrap_data", rd, 64'hFFFF_FFFF_CAFE_F00D);
`endif

        // SD interrupted by reset in its second access: low word lands, high word must not.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b011;
        req_addr   = 64'hC000;
        req_wdata  = 64'hDEAD_BEEF_CAFE_BABE;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 check_eq("acc1_we", 64'(ram_we), 64'h1);
        rst_n = 1'b0;
        #1 check_eq("rst_mid_we", 64'(ram_we), 64'h0);
        check_eq("rst_mid_ready", 64'(req_ready), 64'h1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_mid_no_resp", 64'(resp_valid), 64'h0);
        end
        rst_n = 1'b1;
        model_store(64'hC000, 4, 64'hCAFE_BABE);
        @(negedge clk);
        check_eq("rst_mid_ready_after", 64'(req_ready), 64'h1);
        check_eq("rst_mid_lo", 64'(ram[32'h3000]), 64'hCAFEBABE);
        check_eq("rst_mid_hi", 64'(ram[32'h3001]), 64'h0);

        for (int i = 0; i < 60; i++) begin
            logic        we;
            logic [2:0]  f3;
            logic [63:0] a;
            we = 1'($urandom_range(0, 1));
            f3 = we ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 6));
            a  = 64'h400 + 64'($urandom_range(0, 63));
            do_req(we, f3, a, {$urandom, $urandom}, rd);
        end
        for (int i = 0; i < 16; i++) do_req(1'b0, 3'b011, 64'h400 + 64'(8 * (i % 8)), 64'h0, rd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
